// File: rtl/de1_input_conditioner_if.sv
// Pin-side bundle of the DE1 key/switch front-end: raw levels in, conditioned levels and pulses out.
interface de1_input_conditioner_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] raw_in;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] press_p;
    logic [NUM_CH-1:0] release_p;
    logic [NUM_CH-1:0] repeat_p;
    logic              any_press;

    modport master (
        output raw_in,
        input  level, press_p, release_p, repeat_p, any_press
    );

    modport slave (
        input  raw_in,
        output level, press_p, release_p, repeat_p, any_press
    );
endinterface

// File: rtl/de1_input_conditioner.sv
// Per-channel synchroniser, polarity normaliser, debouncer and edge/auto-repeat pulse generator
// for DE1-SoC keys and switches.
module de1_input_conditioner #(
    parameter int NUM_CH          = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                    CLOCK_50,
    input  logic                    Reset,
    de1_input_conditioner_if.slave  io
);
    localparam logic POL     = (ACTIVE_LOW != 0);
    localparam int   DCW     = $clog2(DEBOUNCE_CYCLES);
    localparam int   RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int   TW      = $clog2(RMAX);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]  RR_LAST = TW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_t;

    logic [NUM_CH-1:0] level_vec;
    logic [NUM_CH-1:0] press_vec;
    logic [NUM_CH-1:0] release_vec;
    logic [NUM_CH-1:0] repeat_vec;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]     sync_reg;
            logic           s;
            logic [DCW-1:0] cnt_reg, cnt_next;
            logic           level_reg, level_next;
            logic           press_reg, press_next;
            logic           release_reg, release_next;

            // Sync flops reset to the idle pin level so reset itself never looks like a press.
            always_ff @(posedge CLOCK_50 or posedge Reset) begin
                if (Reset) begin
                    sync_reg <= {2{POL}};
                end else begin
                    sync_reg <= {sync_reg[0], io.raw_in[gi]};
                end
            end

            assign s = sync_reg[1] ^ POL;

            always_comb begin
                cnt_next     = cnt_reg;
                level_next   = level_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                if (s == level_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == DB_LAST) begin
                    cnt_next     = '0;
                    level_next   = s;
                    press_next   = s;
                    release_next = ~s;
                end else begin
                    cnt_next = cnt_reg + DCW'(1);
                end
            end

            always_ff @(posedge CLOCK_50 or posedge Reset) begin
                if (Reset) begin
                    cnt_reg     <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    level_reg   <= level_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            assign level_vec[gi]   = level_reg;
            assign press_vec[gi]   = press_reg;
            assign release_vec[gi] = release_reg;

            if (REPEAT_EN != 0) begin : g_rpt
                rpt_state_t    state_reg, state_next;
                logic [TW-1:0] timer_reg, timer_next;
                logic          repeat_reg, repeat_next;

                // Driven by the accept strobes, not the registered pulses, so the FSM moves in
                // the same edge that level changes and the first repeat lands REPEAT_DELAY later.
                always_comb begin
                    state_next  = state_reg;
                    timer_next  = timer_reg;
                    repeat_next = 1'b0;
                    case (state_reg)
                        IDLE: begin
                            if (press_next) begin
                                state_next = DELAY;
                                timer_next = '0;
                            end
                        end
                        DELAY: begin
                            if (timer_reg == RD_LAST) begin
                                repeat_next = 1'b1;
                                state_next  = RPT;
                                timer_next  = '0;
                            end else begin
                                timer_next = timer_reg + TW'(1);
                            end
                        end
                        RPT: begin
                            if (timer_reg == RR_LAST) begin
                                repeat_next = 1'b1;
                                timer_next  = '0;
                            end else begin
                                timer_next = timer_reg + TW'(1);
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            timer_next = '0;
                        end
                    endcase
                    // Release wins over a simultaneously expiring timer.
                    if (release_next) begin
                        state_next  = IDLE;
                        timer_next  = '0;
                        repeat_next = 1'b0;
                    end
                end

                always_ff @(posedge CLOCK_50 or posedge Reset) begin
                    if (Reset) begin
                        state_reg  <= IDLE;
                        timer_reg  <= '0;
                        repeat_reg <= 1'b0;
                    end else begin
                        state_reg  <= state_next;
                        timer_reg  <= timer_next;
                        repeat_reg <= repeat_next;
                    end
                end

                assign repeat_vec[gi] = repeat_reg;
            end else begin : g_no_rpt
                assign repeat_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign io.level     = level_vec;
    assign io.press_p   = press_vec;
    assign io.release_p = release_vec;
    assign io.repeat_p  = repeat_vec;
    assign io.any_press = |press_vec;

endmodule

// File: tb/tb_de1_input_conditioner.sv
// Directed bench for de1_input_conditioner with short debounce/repeat timings; checks every
// output every cycle against hand-derived schedules.
module tb_de1_input_conditioner;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miscmp;

    de1_input_conditioner_if #(.NUM_CH(3)) bus ();

    de1_input_conditioner #(
        .NUM_CH          (3),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .io       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [15:0] obs();
        return {3'b000, bus.level, bus.press_p, bus.release_p, bus.repeat_p, bus.any_press};
    endfunction

    function automatic logic [15:0] pack(input logic [2:0] l, input logic [2:0] p,
                                         input logic [2:0] r, input logic [2:0] q);
        return {3'b000, l, p, r, q, |p};
    endfunction

    // One clock, then sample 1 time unit after the edge; inputs changed after this count as
    // driven "at" that edge.
    task automatic cyc(input string tag, input logic [2:0] l, input logic [2:0] p,
                       input logic [2:0] r, input logic [2:0] q);
        @(posedge clk);
        #1;
        chk(tag, obs(), pack(l, p, r, q));
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;

        // 1: reset with all keys released, then quiet
        rst        = 1'b1;
        bus.raw_in = 3'b111;
        #1;
        chk("rst_init", obs(), 16'h0);
        for (int i = 0; i < 3; i++) cyc($sformatf("rst_hold%0d", i), 3'b0, 3'b0, 3'b0, 3'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc($sformatf("idle%0d", i), 3'b0, 3'b0, 3'b0, 3'b0);

        // 2: single press and release on channel 0, released before the first repeat
        bus.raw_in[0] = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            logic l0, p0, r0;
            l0 = (t >= 6) && (t < 14);
            p0 = (t == 6);
            r0 = (t == 14);
            cyc($sformatf("ch0 t=%0d", t), {2'b0, l0}, {2'b0, p0}, {2'b0, r0}, 3'b0);
            if (t == 8) bus.raw_in[0] = 1'b1;
        end

        // 3: 3-cycle glitch and single-cycle chatter on channel 1 are rejected
        bus.raw_in[1] = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("glitch%0d", i), 3'b0, 3'b0, 3'b0, 3'b0);
        bus.raw_in[1] = 1'b1;
        for (int i = 0; i < 6; i++) cyc($sformatf("glitch_q%0d", i), 3'b0, 3'b0, 3'b0, 3'b0);
        for (int i = 0; i < 6; i++) begin
            bus.raw_in[1] = (i % 2 == 1);
            cyc($sformatf("chatter%0d", i), 3'b0, 3'b0, 3'b0, 3'b0);
        end
        for (int i = 0; i < 8; i++) cyc($sformatf("chatter_q%0d", i), 3'b0, 3'b0, 3'b0, 3'b0);

        // 4: long hold on channel 2 with auto-repeat; release lands on a due repeat
        bus.raw_in[2] = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            logic l2, p2, r2, q2;
            l2 = (t >= 6) && (t < 34);
            p2 = (t == 6);
            r2 = (t == 34);
            q2 = (t >= 16) && (t < 34) && ((t - 16) % 3 == 0);
            cyc($sformatf("ch2 t=%0d", t), {l2, 2'b0}, {p2, 2'b0}, {r2, 2'b0}, {q2, 2'b0});
            if (t == 28) bus.raw_in[2] = 1'b1;
        end

        // 5: channels 0 and 1 pressed together, held into repeat
        bus.raw_in[1:0] = 2'b00;
        for (int t = 1; t <= 18; t++) begin
            logic l, p, q;
            l = (t >= 6);
            p = (t == 6);
            q = (t == 16);
            cyc($sformatf("dual t=%0d", t), {1'b0, l, l}, {1'b0, p, p}, 3'b0, {1'b0, q, q});
        end

        // 6: asynchronous reset mid-hold, then re-qualified press and restarted repeat
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async", obs(), 16'h0);
        cyc("rst_mid0", 3'b0, 3'b0, 3'b0, 3'b0);
        cyc("rst_mid1", 3'b0, 3'b0, 3'b0, 3'b0);
        rst = 1'b0;
        for (int t = 1; t <= 22; t++) begin
            logic l, p, q;
            l = (t >= 6);
            p = (t == 6);
            q = (t == 16) || (t == 19) || (t == 22);
            cyc($sformatf("rearm t=%0d", t), {1'b0, l, l}, {1'b0, p, p}, 3'b0, {1'b0, q, q});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
